// File: rtl/uart_byte_tx.sv
// Serial byte transmitter: start bit, 8 data bits LSB first, 1 or 2 stop bits.
// A one-deep holding register lets the next byte queue behind the frame on the line.
module uart_byte_tx #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int MCNT_BAUD  = CLOCK_FREQ / BAUD - 1,
  parameter int STOP_BITS  = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Send_Go,
  input  logic [7:0] Data,
  output logic       uart_tx,
  output logic       Tx_Ready,
  output logic       Tx_Busy,
  output logic       Tx_Done
);

  localparam int DIV_BITS = $clog2(MCNT_BAUD + 1);
  localparam int DIV_W    = (DIV_BITS > 16) ? DIV_BITS : 16;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(MCNT_BAUD);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

  stateT            state_q, state_d;
  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             holdEmpty_q, holdEmpty_d;
  logic             tx_q, tx_d;
  logic             busy_q;
  logic             done_q, done_d;
  logic             bitEnd;

  always_comb begin
    state_d     = state_q;
    divCnt_d    = divCnt_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    holdEmpty_d = holdEmpty_q;
    tx_d        = tx_q;
    bitEnd      = (divCnt_q == DIV_LAST);

    if (state_q != IDLE) begin
      divCnt_d = bitEnd ? '0 : divCnt_q + 1'b1;
    end

    if (Send_Go && holdEmpty_q) begin
      hold_d      = Data;
      holdEmpty_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        divCnt_d = '0;
        bitCnt_d = '0;
        tx_d     = 1'b1;
        if (!holdEmpty_q) begin
          state_d     = START;
          shift_d     = hold_q;
          holdEmpty_d = 1'b1;
          tx_d        = 1'b0;
        end
      end
      START: begin
        if (bitEnd) begin
          state_d  = DATA;
          bitCnt_d = '0;
          tx_d     = shift_q[0];
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitCnt_q == 3'd7) begin
            state_d  = STOP;
            bitCnt_d = '0;
            tx_d     = 1'b1;
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
            tx_d     = shift_q[bitCnt_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (bitEnd) begin
          if (bitCnt_q == STOP_LAST) begin
            bitCnt_d = '0;
            // A byte queued before this edge chains straight into a new start bit.
            if (!holdEmpty_q) begin
              state_d     = START;
              shift_d     = hold_q;
              holdEmpty_d = 1'b1;
              tx_d        = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Looked one clock ahead so the registered pulse lands on the last stop clock.
    done_d = (state_d == STOP) && (divCnt_d == DIV_LAST) && (bitCnt_d == STOP_LAST);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      divCnt_q    <= '0;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      holdEmpty_q <= 1'b1;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      divCnt_q    <= divCnt_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      holdEmpty_q <= holdEmpty_d;
      tx_q        <= tx_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= done_d;
    end
  end

  assign uart_tx  = tx_q;
  assign Tx_Ready = holdEmpty_q;
  assign Tx_Busy  = busy_q;
  assign Tx_Done  = done_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: three instances (1 and 2 stop bits at 434 clocks/bit, and a
// fast 8 clocks/bit variant) share inputs and are checked every clock against a timeline model.
module tb_uart_byte_tx;

  localparam int NDUT = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            sendGo = 1'b0;
  logic [7:0]      data = 8'h00;
  logic [NDUT-1:0] uartTx, txReady, txBusy, txDone;

  int testsRun, testsFailed, cyc;

  // Model: a frame is just a start time and a byte; the line value follows from arithmetic.
  logic       mActive    [NDUT];
  int         mStart     [NDUT];
  logic [7:0] mFrameByte [NDUT];
  logic       mFull      [NDUT];
  logic [7:0] mHold      [NDUT];

  int doneCount [NDUT];
  int doneFirst [NDUT];
  int doneLast  [NDUT];
  int lowCount  [NDUT];

  typedef struct {
    int         edgeOff;
    logic [3:0] exp0;
    logic [3:0] exp1;
    logic [3:0] exp2;
  } vecT;

  vecT vecs [15];

  uart_byte_tx #(.STOP_BITS(1)) dut0 (
    .Clk(clk), .Reset(reset), .Send_Go(sendGo), .Data(data),
    .uart_tx(uartTx[0]), .Tx_Ready(txReady[0]), .Tx_Busy(txBusy[0]), .Tx_Done(txDone[0]));
  uart_byte_tx #(.STOP_BITS(2)) dut1 (
    .Clk(clk), .Reset(reset), .Send_Go(sendGo), .Data(data),
    .uart_tx(uartTx[1]), .Tx_Ready(txReady[1]), .Tx_Busy(txBusy[1]), .Tx_Done(txDone[1]));
  uart_byte_tx #(.CLOCK_FREQ(1_000_000), .BAUD(125_000), .STOP_BITS(2)) dut2 (
    .Clk(clk), .Reset(reset), .Send_Go(sendGo), .Data(data),
    .uart_tx(uartTx[2]), .Tx_Ready(txReady[2]), .Tx_Busy(txBusy[2]), .Tx_Done(txDone[2]));

  always #5 clk = ~clk;

  function automatic int bitLen(input int m);
    return (m == 2) ? 8 : 434;
  endfunction

  function automatic int frameLen(input int m);
    return (9 + ((m == 0) ? 1 : 2)) * bitLen(m);
  endfunction

  function automatic logic [3:0] dutVec(input int m);
    return {uartTx[m], txReady[m], txBusy[m], txDone[m]};
  endfunction

  function automatic logic [3:0] modelVec(input int m);
    int k, idx;
    logic tx, done;
    tx = 1'b1;
    done = 1'b0;
    if (mActive[m]) begin
      k = cyc - mStart[m];
      idx = k / bitLen(m);
      if (idx == 0) tx = 1'b0;
      else if (idx <= 8) tx = mFrameByte[m][idx-1];
      done = (k == frameLen(m) - 1);
    end
    return {tx, !mFull[m], mActive[m], done};
  endfunction

  function automatic logic modelIdle();
    logic idle;
    idle = 1'b1;
    for (int m = 0; m < NDUT; m++) if (mActive[m] || mFull[m]) idle = 1'b0;
    return idle;
  endfunction

  task automatic modelReset();
    for (int m = 0; m < NDUT; m++) begin
      mActive[m] = 1'b0;
      mStart[m] = 0;
      mFrameByte[m] = 8'h00;
      mFull[m] = 1'b0;
      mHold[m] = 8'h00;
    end
  endtask

  // Next frame starts at max(accept edge + 1, end of previous frame).
  task automatic modelEdge(input int m, input logic go, input logic [7:0] d);
    logic readyBefore;
    readyBefore = !mFull[m];
    if (mActive[m] && (cyc - mStart[m] == frameLen(m))) mActive[m] = 1'b0;
    if (!mActive[m] && mFull[m]) begin
      mActive[m] = 1'b1;
      mStart[m] = cyc;
      mFrameByte[m] = mHold[m];
      mFull[m] = 1'b0;
    end
    if (go && readyBefore) begin
      mFull[m] = 1'b1;
      mHold[m] = d;
    end
  endtask

  task automatic clearLog();
    for (int m = 0; m < NDUT; m++) begin
      doneCount[m] = 0;
      doneFirst[m] = -1;
      doneLast[m] = -1;
      lowCount[m] = 0;
    end
  endtask

  task automatic compareVec(input string name, input int m, input logic [3:0] got,
                            input logic [3:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s dut%0d cyc=%0d {tx,ready,busy,done} got=%b expected=%b",
               name, m, cyc, got, exp);
    end
  endtask

  task automatic checkInt(input string name, input int m, input int got, input int exp);
    testsRun++;
    if (got != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s dut%0d cyc=%0d got=%0d expected=%0d", name, m, cyc, got, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    for (int m = 0; m < NDUT; m++) begin
      compareVec(name, m, dutVec(m), modelVec(m));
      if (txDone[m] === 1'b1) begin
        if (doneCount[m] == 0) doneFirst[m] = cyc;
        doneLast[m] = cyc;
        doneCount[m]++;
      end
      if (uartTx[m] === 1'b0) lowCount[m]++;
    end
  endtask

  task automatic tick();
    logic go;
    logic [7:0] d;
    go = sendGo;
    d = data;
    @(posedge clk);
    cyc++;
    if (!reset) for (int m = 0; m < NDUT; m++) modelEdge(m, go, d);
    #1;
    checkOutput("cycle");
  endtask

  task automatic runTo(input int target);
    while (cyc < target) tick();
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    sendGo = 1'b1;
    data = d;
    tick();
    sendGo = 1'b0;
    data = 8'($urandom);
  endtask

  task automatic applyReset(input int cycles);
    reset = 1'b1;
    #1;
    modelReset();
    for (int m = 0; m < NDUT; m++) compareVec("resetState", m, dutVec(m), 4'b1100);
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int budget;
    budget = 20000;
    while (!modelIdle() && budget > 0) begin
      tick();
      budget--;
    end
    tick();
    testsRun++;
    if (budget == 0) begin
      testsFailed++;
      $display("[TB] FAIL %s timeout waiting for idle got=busy expected=idle", name);
    end
  endtask

  initial begin
    int n0;
    testsRun = 0;
    testsFailed = 0;
    cyc = 0;
    modelReset();
    clearLog();

    vecs[0]  = '{0,    4'b1000, 4'b1000, 4'b1000};
    vecs[1]  = '{1,    4'b0110, 4'b0110, 4'b0110};
    vecs[2]  = '{8,    4'b0110, 4'b0110, 4'b0110};
    vecs[3]  = '{9,    4'b0110, 4'b0110, 4'b1110};
    vecs[4]  = '{88,   4'b0110, 4'b0110, 4'b1111};
    vecs[5]  = '{89,   4'b0110, 4'b0110, 4'b1100};
    vecs[6]  = '{434,  4'b0110, 4'b0110, 4'b1100};
    vecs[7]  = '{435,  4'b1110, 4'b1110, 4'b1100};
    vecs[8]  = '{869,  4'b0110, 4'b0110, 4'b1100};
    vecs[9]  = '{3906, 4'b0110, 4'b0110, 4'b1100};
    vecs[10] = '{3907, 4'b1110, 4'b1110, 4'b1100};
    vecs[11] = '{4340, 4'b1111, 4'b1110, 4'b1100};
    vecs[12] = '{4341, 4'b1100, 4'b1110, 4'b1100};
    vecs[13] = '{4774, 4'b1100, 4'b1111, 4'b1100};
    vecs[14] = '{4775, 4'b1100, 4'b1100, 4'b1100};

    #2;
    applyReset(3);

    // 0x55 frame checked at fixed offsets from the accepting edge.
    applyStimulus(8'h55);
    n0 = cyc;
    for (int i = 0; i < 15; i++) begin
      runTo(n0 + vecs[i].edgeOff);
      compareVec($sformatf("vec%0d", i), 0, dutVec(0), vecs[i].exp0);
      compareVec($sformatf("vec%0d", i), 1, dutVec(1), vecs[i].exp1);
      compareVec($sformatf("vec%0d", i), 2, dutVec(2), vecs[i].exp2);
    end
    waitIdle("t1Drain");

    // Back-to-back: second byte queued while the first is on the line.
    clearLog();
    applyStimulus(8'hA3);
    n0 = cyc;
    runTo(n0 + 49);
    applyStimulus(8'h0F);
    runTo(n0 + 2 * 4774 + 20);
    for (int m = 0; m < NDUT; m++) begin
      checkInt("t2DoneCount", m, doneCount[m], 2);
      checkInt("t2DoneGap", m, doneLast[m] - doneFirst[m], frameLen(m));
    end
    waitIdle("t2Drain");

    // Send_Go while holding is full is ignored.
    clearLog();
    applyStimulus(8'h3C);
    n0 = cyc;
    runTo(n0 + 9);
    applyStimulus(8'h81);
    runTo(n0 + 19);
    sendGo = 1'b1;
    data = 8'hFF;
    repeat (20) tick();
    sendGo = 1'b0;
    for (int m = 0; m < NDUT; m++) checkInt("t3ReadyLow", m, int'(txReady[m]), 0);
    runTo(n0 + 3 * 4774);
    for (int m = 0; m < NDUT; m++) checkInt("t3DoneCount", m, doneCount[m], 2);
    waitIdle("t3Drain");

    // All-zero byte: line low for start + 8 data bits, Tx_Done at the frame's last clock.
    clearLog();
    applyStimulus(8'h00);
    n0 = cyc;
    runTo(n0 + 4780);
    for (int m = 0; m < NDUT; m++) begin
      checkInt("t4LowClocks", m, lowCount[m], 9 * bitLen(m));
      checkInt("t4DoneClock", m, doneFirst[m] - n0, frameLen(m));
      checkInt("t4DoneCount", m, doneCount[m], 1);
    end
    waitIdle("t4Drain");

    // Reset mid data bit 4 with a byte queued: abort, nothing further sent.
    applyStimulus(8'hC6);
    n0 = cyc;
    runTo(n0 + 19);
    applyStimulus(8'h12);
    runTo(n0 + 1 + 434 * 5 + 200);
    clearLog();
    applyReset(2);
    repeat (1000) tick();
    for (int m = 0; m < NDUT; m++) begin
      checkInt("t5NoDone", m, doneCount[m], 0);
      checkInt("t5NoLow", m, lowCount[m], 0);
    end

    // Send_Go on the Tx_Done clock with holding empty: exactly one idle clock.
    applyStimulus(8'h5A);
    for (int i = 0; i < 6000 && txDone[0] !== 1'b1; i++) tick();
    checkInt("t6DoneSeen", 0, int'(txDone[0]), 1);
    applyStimulus(8'h96);
    compareVec("t6IdleClock", 0, dutVec(0), 4'b1000);
    tick();
    compareVec("t6StartBit", 0, dutVec(0), 4'b0110);
    waitIdle("t6Drain");

    // Random traffic against the model.
    for (int i = 0; i < 12000; i++) begin
      sendGo = ($urandom_range(0, 39) == 0);
      data = 8'($urandom);
      tick();
    end
    sendGo = 1'b0;
    waitIdle("randDrain");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
